stopwatch_counter: RTL
======================

# stopwatch_counter

Timekeeping datapath for the stopwatch. It consumes the mode controls issued by the control FSM (`use_1hz`, `use_2hz`, `sel_minutes`, `sel_seconds`, `blink_enable`, `count_enable`) together with the divider tick pulses. It maintains the MM:SS value as four BCD digits and generates per-field blank masks for adjust-mode blinking. Its outputs feed the seven-segment display multiplexer.

## Interface
- `MIN_MAX`, default 59: highest minutes value before wrap to 0. Legal range 1..99.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `clr` in 1: synchronous clear of the time value to 00:00.
- `tick_1hz` in 1: one-cycle pulse, 1 Hz, from the clock divider.
- `tick_2hz` in 1: one-cycle pulse, 2 Hz, from the clock divider.
- `tick_blink` in 1: one-cycle pulse at the blink toggle rate, from the clock divider.
- `use_1hz` in 1: control FSM qualifies the 1 Hz tick.
- `use_2hz` in 1: control FSM qualifies the 2 Hz tick.
- `sel_minutes` in 1: adjust-minutes mode.
- `sel_seconds` in 1: adjust-seconds mode.
- `blink_enable` in 1: adjust-mode blinking active.
- `count_enable` in 1: free-running count permitted.
- `min_tens` out 4: minutes tens digit, BCD.
- `min_ones` out 4: minutes ones digit, BCD.
- `sec_tens` out 4: seconds tens digit, BCD, range 0..5.
- `sec_ones` out 4: seconds ones digit, BCD.
- `blank_min` out 1: when 1, the display blanks the minutes digits.
- `blank_sec` out 1: when 1, the display blanks the seconds digits.
- `rollover` out 1: one-cycle pulse when a free-running count wraps MIN_MAX:59 to 00:00.

## Operation
**Update events.** Each cycle, at most one update event applies, chosen in this priority order:
1. `clr`: all digits are set to 0. `rollover` stays 0.
2. Adjust-minutes (`use_2hz & tick_2hz & sel_minutes`): minutes increments by 1. MIN_MAX wraps to 0. Seconds are unchanged. There is no carry and no `rollover`.
3. Adjust-seconds (`use_2hz & tick_2hz & sel_seconds & ~sel_minutes`): seconds increments by 1. 59 wraps to 0. Minutes are unchanged. There is no carry.
4. Count (`use_1hz & tick_1hz & count_enable`): seconds increments. A wrap from 59 to 0 carries +1 into minutes. A minutes wrap from MIN_MAX to 0 with a seconds carry pulses `rollover` for one cycle.
- If none of the above applies, the time value holds.

**BCD arithmetic.**
- Each ones digit wraps 9 to 0 and carries into its tens digit.
- Field wrap is detected on the full two-digit value (e.g. 5,9 for seconds; MIN_MAX for minutes), not per digit.
- Digits never hold values above 9, and never exceed the field maximum.

**Tick gating.**
- `tick_1hz` is ignored whenever `use_1hz` is 0.
- `tick_2hz` is ignored whenever `use_2hz` is 0.
- A tick arriving while its gate is low is dropped, not queued.

**Illegal control combinations.**
- `sel_minutes & sel_seconds`: minutes priority applies.
- `count_enable` high during adjust: adjust priority applies.

**Blink phase.**
- `phase` is a 1-bit register.
- While `blink_enable` = 0, `phase` is forced to 0.
- While `blink_enable` = 1, `phase` toggles on each `tick_blink`.
- `blank_min = blink_enable & sel_minutes & phase`.
- `blank_sec = blink_enable & sel_seconds & ~sel_minutes & phase`.
- The selected field is always visible on the first cycle of entering adjust.

## Timing
**Reset values.** All digits 0, `phase` 0, `blank_min` 0, `blank_sec` 0, `rollover` 0. Reset takes effect immediately (asynchronous) and overrides any in-flight tick.

**Latency.**
- All outputs are registered.
- A qualifying event sampled at edge N is reflected on the digits after edge N.
- `rollover` asserts after the same edge as the digits becoming 00:00, and deasserts after the next edge.

**Cycle-level rules.**
- `clr` takes effect one cycle later, regardless of ticks in the same cycle.
- The blank outputs follow `phase` and the control inputs one cycle after the `tick_blink` or control change. They are registered, so there is no combinational glitch to the display.
- A mode change and a tick in the same cycle: the tick is evaluated against the control values sampled at that edge.

## Test plan
- Free-run rollover: preload 00:58 by counting, with `count_enable=1`, `use_1hz=1`. Two `tick_1hz` pulses → 00:59, then 01:00, with `rollover`=0.
- Full wrap: MIN_MAX=59, value 59:59, one count tick → 00:00 and a one-cycle `rollover`=1.
- Adjust-seconds isolation: value 03:59, `use_2hz=1`, `sel_seconds=1`, one `tick_2hz` → 03:00. Minutes are not incremented, `rollover`=0. A `tick_1hz` in the same window is ignored.
- Adjust-minutes wrap: value 59:30, `sel_minutes=1`, `tick_2hz` → 00:30.
- Blink: `blink_enable=1`, `sel_minutes=1`.
  - `blank_min` is 0, then toggles 1, 0, 1 on successive `tick_blink` pulses; `blank_sec` stays 0.
  - Dropping `blink_enable` → both blank outputs 0 next cycle; on re-entry the first phase is visible.
- Reset/clear: assert `rst` mid-count at 12:34 asynchronously (between edges) → all outputs 0 immediately. Separately, `clr` coincident with a count tick → 00:00 with `rollover`=0.

Source files
------------

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS timekeeping datapath with four BCD digits,
// tick-qualified adjust/count updates and registered blink masks.
module stopwatch_counter #(
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_blink,
  input  logic       use_1hz,
  input  logic       use_2hz,
  input  logic       sel_minutes,
  input  logic       sel_seconds,
  input  logic       blink_enable,
  input  logic       count_enable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       rollover
);

  localparam logic [3:0] MIN_MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MIN_MAX_O = 4'(MIN_MAX % 10);
  localparam logic [3:0] SEC_MAX_T = 4'd5;
  localparam logic [3:0] SEC_MAX_O = 4'd9;

  // Two-digit BCD increment; wrap is decided on the whole field value.
  function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o,
                                         input logic [3:0] max_t, input logic [3:0] max_o);
    logic [7:0] r;
    if ((t == max_t) && (o == max_o)) begin
      r = 8'h00;
    end else if (o == 4'd9) begin
      r = {t + 4'd1, 4'd0};
    end else begin
      r = {t, o + 4'd1};
    end
    return r;
  endfunction

  logic [3:0] min_tens_r, min_ones_r, sec_tens_r, sec_ones_r;
  logic [3:0] min_tens_s, min_ones_s, sec_tens_s, sec_ones_s;
  logic       phase_r, phase_s;
  logic       blank_min_r, blank_sec_r, rollover_r;
  logic       blank_min_s, blank_sec_s, rollover_s;
  logic       adj_min_s, adj_sec_s, count_s;
  logic       sec_at_max_s, min_at_max_s;

  assign adj_min_s    = use_2hz & tick_2hz & sel_minutes;
  assign adj_sec_s    = use_2hz & tick_2hz & sel_seconds & ~sel_minutes;
  assign count_s      = use_1hz & tick_1hz & count_enable;
  assign sec_at_max_s = (sec_tens_r == SEC_MAX_T) && (sec_ones_r == SEC_MAX_O);
  assign min_at_max_s = (min_tens_r == MIN_MAX_T) && (min_ones_r == MIN_MAX_O);

  // Pick the single highest-priority update event and form the next time value.
  always_comb begin
    min_tens_s = min_tens_r;
    min_ones_s = min_ones_r;
    sec_tens_s = sec_tens_r;
    sec_ones_s = sec_ones_r;
    rollover_s = 1'b0;
    if (clr) begin
      min_tens_s = 4'd0;
      min_ones_s = 4'd0;
      sec_tens_s = 4'd0;
      sec_ones_s = 4'd0;
    end else if (adj_min_s) begin
      {min_tens_s, min_ones_s} = bcd_inc(min_tens_r, min_ones_r, MIN_MAX_T, MIN_MAX_O);
    end else if (adj_sec_s) begin
      {sec_tens_s, sec_ones_s} = bcd_inc(sec_tens_r, sec_ones_r, SEC_MAX_T, SEC_MAX_O);
    end else if (count_s) begin
      {sec_tens_s, sec_ones_s} = bcd_inc(sec_tens_r, sec_ones_r, SEC_MAX_T, SEC_MAX_O);
      if (sec_at_max_s) begin
        {min_tens_s, min_ones_s} = bcd_inc(min_tens_r, min_ones_r, MIN_MAX_T, MIN_MAX_O);
        rollover_s = min_at_max_s;
      end else begin
        rollover_s = 1'b0;
      end
    end else begin
      rollover_s = 1'b0;
    end
  end

  // Blink phase toggles on tick_blink only while blinking; masks use the new phase.
  always_comb begin
    phase_s     = 1'b0;
    if (blink_enable) begin
      phase_s = phase_r ^ tick_blink;
    end else begin
      phase_s = 1'b0;
    end
    blank_min_s = blink_enable & sel_minutes & phase_s;
    blank_sec_s = blink_enable & sel_seconds & ~sel_minutes & phase_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_tens_r  <= 4'd0;
      min_ones_r  <= 4'd0;
      sec_tens_r  <= 4'd0;
      sec_ones_r  <= 4'd0;
      phase_r     <= 1'b0;
      blank_min_r <= 1'b0;
      blank_sec_r <= 1'b0;
      rollover_r  <= 1'b0;
    end else begin
      min_tens_r  <= min_tens_s;
      min_ones_r  <= min_ones_s;
      sec_tens_r  <= sec_tens_s;
      sec_ones_r  <= sec_ones_s;
      phase_r     <= phase_s;
      blank_min_r <= blank_min_s;
      blank_sec_r <= blank_sec_s;
      rollover_r  <= rollover_s;
    end
  end

  assign min_tens  = min_tens_r;
  assign min_ones  = min_ones_r;
  assign sec_tens  = sec_tens_r;
  assign sec_ones  = sec_ones_r;
  assign blank_min = blank_min_r;
  assign blank_sec = blank_sec_r;
  assign rollover  = rollover_r;

endmodule
